// File: rtl/uart_byte_rx_pkg.sv
// Shared definitions for the 8N1 byte receiver: state encoding and defaults.
package uart_byte_rx_pkg;

    localparam int DEF_CLKS_PER_BIT = 16;
    localparam int DATA_W           = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_byte_rx_if.sv
// Signal bundle between the serial line, the receiver and the downstream byte register.
// Strobe semantics: valid is a one-cycle pulse with no ready/backpressure; the
// consumer must take out in the valid cycle (out also holds until the next valid).
// frame_err is a one-cycle pulse of its own and never coincides with valid.
interface uart_byte_rx_if;
    import uart_byte_rx_pkg::*;

    logic              rxd;
    logic [DATA_W-1:0] out;
    logic              valid;
    logic              frame_err;
    logic              busy;
    rx_state_t         state;     // FSM state, exported for observation

    modport master (
        output rxd,
        input  out, valid, frame_err, busy, state
    );

    modport slave (
        input  rxd,
        output out, valid, frame_err, busy, state
    );

endinterface

// File: rtl/uart_byte_rx_sync2.sv
// Two-flop synchronizer for an asynchronous input; resets to 1 (idle line level).
module uart_byte_rx_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops; the first may go metastable, the second settles it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 serial receiver: mid-bit sampling, LSB-first assembly, one-cycle valid or
// frame_err strobe after the stop bit sample.
module uart_byte_rx
    import uart_byte_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic           clk,
    input  logic           rst,
    uart_byte_rx_if.slave  bus
);

    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic              rxd_s;
    rx_state_t         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;

    uart_byte_rx_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.rxd),
        .q   (rxd_s)
    );

    // State, counters, shift register and registered strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    // Next-state logic: half a bit to the start-bit centre, then a full bit per sample.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        out_d   = out_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rxd_s) begin
                    state_d = START;
                end
            end

            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    idx_d = '0;
                    // A line already back high at mid-start is a glitch, not a frame.
                    state_d = rxd_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rxd_s;
                    if (idx_q == 3'd7) begin
                        idx_d   = '0;
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rxd_s) begin
                        out_d   = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            BREAK: begin
                // Hold off until the line returns high so a stuck-low line cannot retrigger.
                cnt_d = '0;
                if (rxd_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    assign bus.out       = out_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.state     = state_q;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx at 16 clocks per bit.
module tb_uart_byte_rx;
    import uart_byte_rx_pkg::*;

    localparam int N = 16;
    // Start bit driven just after negedge P: sync flops at P+1/P+2, FSM sees it at
    // P+3 (t0), stop sampled at t0+152, strobe observed at the negedge after that.
    localparam int STROBE_LAT = 155;

    logic clk = 1'b0;
    logic rst;

    // Clock and reset
    always #5 clk = ~clk;

    uart_byte_rx_if bus ();

    uart_byte_rx #(.CLKS_PER_BIT(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: log every strobe with its cycle number
    int         v_cyc_q[$];
    logic [7:0] v_dat_q[$];
    logic       v_busy_q[$];
    int         f_cyc_q[$];
    logic [7:0] f_out_q[$];
    int         both_cnt = 0;
    int         long_cnt = 0;
    logic       prev_v = 1'b0;
    logic       prev_f = 1'b0;

    always @(negedge clk) begin
        if (bus.valid) begin
            v_cyc_q.push_back(cyc);
            v_dat_q.push_back(bus.out);
            v_busy_q.push_back(bus.busy);
        end
        if (bus.frame_err) begin
            f_cyc_q.push_back(cyc);
            f_out_q.push_back(bus.out);
        end
        if (bus.valid && bus.frame_err) both_cnt <= both_cnt + 1;
        if ((bus.valid && prev_v) || (bus.frame_err && prev_f)) long_cnt <= long_cnt + 1;
        prev_v <= bus.valid;
        prev_f <= bus.frame_err;
    end

    // Scoreboard
    logic [7:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Driver: drives the first ncyc clocks of a 10-bit frame; call at a negedge.
    task automatic drive_frame(input logic [7:0] d, input logic stop, input int ncyc,
                               output int ts);
        ts = cyc;
        for (int i = 0; i < ncyc; i++) begin
            int b;
            b = i / N;
            if (b == 0)      bus.rxd = 1'b0;
            else if (b <= 8) bus.rxd = d[b-1];
            else             bus.rxd = stop;
            @(negedge clk);
        end
    endtask

    // Expect exactly one valid since the last call, at t_exp, carrying exp_q's head.
    task automatic expect_valid(input string tag, input int t_exp);
        check({tag, "_nvalid"}, v_cyc_q.size(), 1);
        check({tag, "_nferr"}, f_cyc_q.size(), 0);
        if (v_cyc_q.size() > 0 && exp_q.size() > 0) begin
            check({tag, "_time"}, v_cyc_q.pop_front(), t_exp);
            check({tag, "_data"}, v_dat_q.pop_front(), exp_q.pop_front());
            check({tag, "_busy"}, v_busy_q.pop_front(), 0);
        end
        v_cyc_q.delete();
        v_dat_q.delete();
        v_busy_q.delete();
    endtask

    // Directed sequence
    initial begin
        int ts, ts2;

        bus.rxd = 1'b1;
        rst     = 1'b1;
        #1;
        check("rst_out",   bus.out, 8'h00);
        check("rst_valid", bus.valid, 0);
        check("rst_ferr",  bus.frame_err, 0);
        check("rst_busy",  bus.busy, 0);
        check("rst_state", bus.state, IDLE);
        wait_neg(2);
        rst = 1'b0;

        // Idle line: nothing moves
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            check("idle_quiet", {bus.out, bus.valid, bus.frame_err, bus.busy}, 11'h000);
        end

        // Single byte A5
        exp_q.push_back(8'hA5);
        drive_frame(8'hA5, 1'b1, 160, ts);
        expect_valid("a5", ts + STROBE_LAT);
        check("a5_out_hold", bus.out, 8'hA5);

        // Back-to-back 3C, FF with no gap
        exp_q.push_back(8'h3C);
        drive_frame(8'h3C, 1'b1, 160, ts);
        expect_valid("b2b_3c", ts + STROBE_LAT);
        exp_q.push_back(8'hFF);
        drive_frame(8'hFF, 1'b1, 160, ts2);
        expect_valid("b2b_ff", ts + 160 + STROBE_LAT);
        check("b2b_out", bus.out, 8'hFF);

        // Glitch: 4 clocks low
        bus.rxd = 1'b0;
        wait_neg(4);
        check("glitch_busy", bus.busy, 1);
        bus.rxd = 1'b1;
        wait_neg(10);
        check("glitch_state", bus.state, IDLE);
        check("glitch_nvalid", v_cyc_q.size(), 0);
        check("glitch_nferr", f_cyc_q.size(), 0);
        check("glitch_out", bus.out, 8'hFF);

        // Frame error: 55 with low stop bit, line held low 100 more clocks
        drive_frame(8'h55, 1'b0, 160, ts);
        wait_neg(100);
        check("ferr_state", bus.state, BREAK);
        check("ferr_busy", bus.busy, 1);
        check("ferr_nferr", f_cyc_q.size(), 1);
        check("ferr_nvalid", v_cyc_q.size(), 0);
        if (f_cyc_q.size() > 0) begin
            check("ferr_time", f_cyc_q.pop_front(), ts + STROBE_LAT);
            check("ferr_out", f_out_q.pop_front(), 8'hFF);
        end
        bus.rxd = 1'b1;
        wait_neg(5);
        check("ferr_release", bus.state, IDLE);
        check("ferr_out_after", bus.out, 8'hFF);

        exp_q.push_back(8'h12);
        drive_frame(8'h12, 1'b1, 160, ts);
        expect_valid("after_ferr_12", ts + STROBE_LAT);
        check("after_ferr_out", bus.out, 8'h12);

        // Reset mid-data of C3
        drive_frame(8'hC3, 1'b1, 72, ts);
        check("pre_rst_busy", bus.busy, 1);
        rst     = 1'b1;
        bus.rxd = 1'b1;
        #1;
        check("midrst_out",   bus.out, 8'h00);
        check("midrst_busy",  bus.busy, 0);
        check("midrst_valid", bus.valid, 0);
        check("midrst_state", bus.state, IDLE);
        wait_neg(1);
        rst = 1'b0;
        wait_neg(120);
        check("midrst_nvalid", v_cyc_q.size(), 0);
        check("midrst_nferr", f_cyc_q.size(), 0);
        check("midrst_out_hold", bus.out, 8'h00);

        exp_q.push_back(8'h81);
        drive_frame(8'h81, 1'b1, 160, ts);
        expect_valid("post_rst_81", ts + STROBE_LAT);
        check("post_rst_out", bus.out, 8'h81);

        // Global strobe properties
        check("strobe_exclusive", both_cnt, 0);
        check("strobe_one_cycle", long_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_byte_rx.md
Name: uart_byte_rx

Overview:
- Serial-to-parallel receive stage directly upstream of the 8-bit byte register.
- Converts an asynchronous 8N1 serial line (1 start bit, 8 data bits, 1 stop bit, no parity) into an 8-bit parallel byte, with a one-cycle valid strobe.
- The `out` and `valid` outputs drive the downstream register's data input and load/enable.
- Frame errors are flagged and never presented as data.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit period (N); even, >= 4.
- DATA_W, 8, data bits per frame; fixed at 8 for this design and not overridden.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset; clears all state immediately.
- rxd  input  1  raw serial line, idle high, asynchronous to clk.
- out  output 8  last correctly received byte, LSB received first.
- valid  output 1  one-cycle pulse: `out` was just updated with a new byte.
- frame_err  output 1  one-cycle pulse: stop bit sampled low; frame discarded.
- busy  output 1  high while a frame is in progress (any state other than IDLE).

Behaviour:
- Reset: rst asynchronous active-high.
  - Synchronizer flops reset to 1.
  - state=IDLE, out=8'h00, valid=0, frame_err=0, busy=0, all counters=0.
  - Reset mid-frame abandons the frame; no strobe is produced.
- Input sync: rxd passes through 2 flops (rxd_s) before any use; 2-cycle input latency.
- Let H=N/2. t0 = the clk edge at which IDLE first sees rxd_s==0.
- States and transitions:
  - IDLE: busy=0. On rxd_s==0 go to START with cnt=0.
  - START: count to H-1, then sample at t0+H. If rxd_s==1 (glitch), return to IDLE with no strobe. Else go to DATA, cnt=0, idx=0.
  - DATA: sample every N cycles. Bit k (k=0..7) sampled at t0+H+N*(k+1) into shift register position k (LSB first). After k=7 go to STOP.
  - STOP: sample at t0+H+9N.
    - rxd_s==1: out<=shift register; valid=1 on the next cycle; go to IDLE.
    - rxd_s==0: frame_err=1 on the next cycle; out unchanged; go to BREAK.
  - BREAK: wait until rxd_s==1, then go to IDLE. This prevents a held-low line from retriggering.
- Latency: for N=16, the stop sample is at t0+152; valid/frame_err are high for exactly the cycle after it.
- Back-to-back frames: IDLE is re-entered immediately after the stop sample. A start edge arriving half a bit later is caught; no gap bits are required.
- valid and frame_err are mutually exclusive and never asserted for more than 1 cycle.
- `out` changes only together with valid.
- Counters:
  - Bit-time counter width is clog2(CLKS_PER_BIT); it wraps to 0 at N-1.
  - Bit index is 3 bits.
  - No arithmetic overflow is possible in legal operation.
- Downstream has no backpressure. The consumer captures `out` in the valid cycle; `out` also holds until the next valid.

Decomposition:
- Shared package: state encoding constants IDLE/START/DATA/STOP/BREAK (3-bit) and the default CLKS_PER_BIT.
- One natural sub-module: sync2, a 2-flop synchronizer with asynchronous active-high reset to 1, reusable for other asynchronous inputs.
- FSM, counters and shift register stay in uart_byte_rx.

Test Plan (N=16):
- Reset, rxd held high 200 cycles -> out=8'h00, valid=0, frame_err=0, busy=0 throughout.
- Send 8'hA5 (start, bits 1,0,1,0,0,1,0,1 LSB first, stop=1) -> a single valid pulse at t0+153; out=8'hA5; busy falls at the same time.
- Send 8'h3C then 8'hFF back-to-back with no idle gap -> two valid pulses exactly 160 cycles apart; out=8'h3C, then 8'hFF.
- Glitch: rxd low for 4 cycles, then high -> START rejects it at t0+8; no valid, no frame_err; state returns to IDLE.
- Frame error: send 8'h55 with stop bit 0, keep rxd low 100 more cycles, then high -> frame_err pulse at t0+153; out keeps its previous value. Then send 8'h12 -> valid with out=8'h12.
- Assert rst for 1 cycle mid-data (t0+70) of 8'hC3 -> outputs clear immediately, no strobe. A subsequent frame 8'h81 is received correctly, with out=8'h81.
